// File: rtl/lbist_pkg.sv
// Shared definitions for the LBIST mid-section controllers: default widths
// and the state encodings of the fault-campaign sequencer.
package lbist_pkg;

    localparam int DEF_OUT_BITS = 26;
    localparam int DEF_CNT_W    = 16;

    localparam int FCC_STATE_W = 3;

    localparam logic [FCC_STATE_W-1:0] FCC_IDLE   = 3'd0;
    localparam logic [FCC_STATE_W-1:0] FCC_INJECT = 3'd1;
    localparam logic [FCC_STATE_W-1:0] FCC_SEED   = 3'd2;
    localparam logic [FCC_STATE_W-1:0] FCC_APPLY  = 3'd3;
    localparam logic [FCC_STATE_W-1:0] FCC_DRAIN  = 3'd4;
    localparam logic [FCC_STATE_W-1:0] FCC_EVAL   = 3'd5;
    localparam logic [FCC_STATE_W-1:0] FCC_DONE   = 3'd6;

    typedef enum logic [FCC_STATE_W-1:0] {
        S_IDLE   = FCC_IDLE,
        S_INJECT = FCC_INJECT,
        S_SEED   = FCC_SEED,
        S_APPLY  = FCC_APPLY,
        S_DRAIN  = FCC_DRAIN,
        S_EVAL   = FCC_EVAL,
        S_DONE   = FCC_DONE
    } fcc_state_t;

endpackage

// File: rtl/resp_cmp.sv
// Response comparator: full-width XOR-reduce of faulty vs fault-free CUT
// outputs, folded into a sticky per-fault detection flag.
module resp_cmp
    import lbist_pkg::*;
#(
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmp_v,
    input  logic                clr,
    input  logic [OUT_BITS-1:0] cut_op,
    input  logic [OUT_BITS-1:0] ff_op,
    output logic                det
);

    logic det_q;
    logic hit;

    // A compared pattern mismatches when any response bit differs.
    assign hit = cmp_v & (|(cut_op ^ ff_op));

    // The current hit is forwarded so fault dropping reacts on the very
    // cycle the mismatch is compared; det_q keeps it for later cycles.
    assign det = det_q | hit;

    // Sticky flag, cleared when the next fault is injected.
    always_ff @(posedge clk) begin
        if (!rst) begin
            det_q <= 1'b0;
        end else if (clr) begin
            det_q <= 1'b0;
        end else if (hit) begin
            det_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-campaign sequencer: injects each fault from the FIL, reseeds and
// steps the TPG through a pattern window, and tallies faults evaluated and
// faults detected until the FIL reports the list exhausted.
module fault_campaign_ctrl
    import lbist_pkg::*;
#(
    parameter int OUT_BITS      = DEF_OUT_BITS,
    parameter int PAT_PER_FAULT = 64,
    parameter int CNT_W         = DEF_CNT_W,
    parameter bit DROP          = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                FIL_INC,
    input  logic                FIL_END,
    output logic                PAT_RST,
    output logic                PAT_EN,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    fault_cnt,
    output logic [CNT_W-1:0]    detect_cnt
);

    localparam int PC_W = (PAT_PER_FAULT > 1) ? $clog2(PAT_PER_FAULT) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAT_PER_FAULT - 1);

    fcc_state_t      state;
    logic [PC_W-1:0] pc;
    logic            cmp_v;
    logic            det;
    logic            window_end;

    // The window closes on its last pattern, or early once a fault is seen.
    assign window_end = (pc == PC_LAST) || (DROP && det);

    // The TPG presents a pattern the cycle after PAT_EN, so compare then.
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp_v <= 1'b0;
        end else begin
            cmp_v <= PAT_EN;
        end
    end

    resp_cmp #(
        .OUT_BITS (OUT_BITS)
    ) u_resp_cmp (
        .clk    (clk),
        .rst    (rst),
        .cmp_v  (cmp_v),
        .clr    (FIL_INC),
        .cut_op (CUT_OP),
        .ff_op  (FF_OP),
        .det    (det)
    );

    // Campaign FSM with registered strobes: each output is loaded on the
    // transition into the state that owns it.
    // NOTE: the strobes default low every cycle so a missed branch cannot
    // hold one high; busy/done/counters are held explicitly instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            FIL_INC    <= 1'b0;
            PAT_RST    <= 1'b0;
            PAT_EN     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault_cnt  <= '0;
            detect_cnt <= '0;
        end else begin
            FIL_INC <= 1'b0;
            PAT_RST <= 1'b0;
            PAT_EN  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_INJECT;
                        FIL_INC    <= 1'b1;
                        busy       <= 1'b1;
                        fault_cnt  <= '0;
                        detect_cnt <= '0;
                    end
                end
                S_INJECT: begin
                    state   <= S_SEED;
                    PAT_RST <= 1'b1;
                end
                S_SEED: begin
                    state  <= S_APPLY;
                    pc     <= '0;
                    PAT_EN <= 1'b1;
                end
                S_APPLY: begin
                    pc <= pc + PC_W'(1);
                    if (window_end) begin
                        state <= S_DRAIN;
                    end else begin
                        PAT_EN <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (!(&fault_cnt)) begin
                        fault_cnt <= fault_cnt + CNT_W'(1);
                    end
                    if (det && !(&detect_cnt)) begin
                        detect_cnt <= detect_cnt + CNT_W'(1);
                    end
                    if (FIL_END) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_INJECT;
                        FIL_INC <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: three configurations (4-pattern no-drop,
// 64-pattern with drop, 2-bit counters) driven by FIL/TPG/CUT stubs, with
// campaign results checked from a scoreboard queue when done rises.
module tb_fault_campaign_ctrl;
    import lbist_pkg::*;

    localparam int OB = 26;

    typedef struct {
        int fc;
        int dc;
        int pat_en;
        int incs;
        int spacing;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start_v   [3];
    logic          fil_inc_v [3];
    logic          fil_end_v [3];
    logic          pat_rst_v [3];
    logic          pat_en_v  [3];
    logic [OB-1:0] cut_v     [3];
    logic [OB-1:0] ff_v      [3];
    logic          busy_v    [3];
    logic          done_v    [3];
    logic [15:0]   fc_a, dc_a, fc_b, dc_b;
    logic [1:0]    fc_c, dc_c;

    int            nf    [3];
    int            mode  [3];
    int            tgt   [3];
    int            inc_n [3];
    int            pidx  [3];
    logic [OB-1:0] mask;
    int            sel;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input longint obs, input longint req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, req, $time);
        end
    endtask

    fault_campaign_ctrl #(.OUT_BITS(OB), .PAT_PER_FAULT(4), .CNT_W(16), .DROP(1'b0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .FIL_INC(fil_inc_v[0]), .FIL_END(fil_end_v[0]),
        .PAT_RST(pat_rst_v[0]), .PAT_EN(pat_en_v[0]), .CUT_OP(cut_v[0]), .FF_OP(ff_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .fault_cnt(fc_a), .detect_cnt(dc_a));

    fault_campaign_ctrl #(.OUT_BITS(OB), .PAT_PER_FAULT(64), .CNT_W(16), .DROP(1'b1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .FIL_INC(fil_inc_v[1]), .FIL_END(fil_end_v[1]),
        .PAT_RST(pat_rst_v[1]), .PAT_EN(pat_en_v[1]), .CUT_OP(cut_v[1]), .FF_OP(ff_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .fault_cnt(fc_b), .detect_cnt(dc_b));

    fault_campaign_ctrl #(.OUT_BITS(OB), .PAT_PER_FAULT(4), .CNT_W(2), .DROP(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .FIL_INC(fil_inc_v[2]), .FIL_END(fil_end_v[2]),
        .PAT_RST(pat_rst_v[2]), .PAT_EN(pat_en_v[2]), .CUT_OP(cut_v[2]), .FF_OP(ff_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .fault_cnt(fc_c), .detect_cnt(dc_c));

    // FIL stub counts injections; TPG stub counts advances since reseed.
    // Modes: 0 never mismatch, 1 always, 2 only on pattern tgt,
    // 3 always but only while the first fault is injected.
    for (genvar g = 0; g < 3; g++) begin : g_stub
        always @(posedge clk) begin
            if (!rst) begin
                inc_n[g] <= 0;
                pidx[g]  <= 0;
            end else begin
                if (fil_inc_v[g]) inc_n[g] <= inc_n[g] + 1;
                if (pat_rst_v[g])     pidx[g] <= 0;
                else if (pat_en_v[g]) pidx[g] <= pidx[g] + 1;
            end
        end
        assign fil_end_v[g] = (inc_n[g] >= nf[g]);
        assign ff_v[g]      = OB'(pidx[g] * 32'h9e37 + 7);
        assign cut_v[g]     = ff_v[g] ^ (((mode[g] == 1) || (mode[g] == 2 && pidx[g] == tgt[g]) ||
                                          (mode[g] == 3 && inc_n[g] == 1)) ? mask : '0);
    end

    // Observation mux onto the DUT currently under test.
    logic        m_done, m_fil_inc, m_pat_en;
    logic [15:0] m_fc, m_dc;
    always_comb begin
        m_done    = done_v[sel];
        m_fil_inc = fil_inc_v[sel];
        m_pat_en  = pat_en_v[sel];
        case (sel)
            0:       begin m_fc = fc_a;          m_dc = dc_a;          end
            1:       begin m_fc = fc_b;          m_dc = dc_b;          end
            default: begin m_fc = {14'b0, fc_c}; m_dc = {14'b0, dc_c}; end
        endcase
    end

    // Monitor: counts strobes and pulse spacing, pops the scoreboard on done.
    int   cyc = 0, n_inc = 0, n_pe = 0, last_inc = -1, sp = 0;
    int   sp_min = 1000000, sp_max = 0;
    logic prev_inc = 1'b0, done_seen = 1'b0, mon_clr = 1'b0;
    exp_t e_mon;
    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            n_inc = 0; n_pe = 0; last_inc = -1; sp_min = 1000000; sp_max = 0;
            prev_inc = 1'b0; done_seen = 1'b0;
        end else begin
            if (m_fil_inc) begin
                check("fil_inc_back_to_back", prev_inc, 0);
                if (last_inc >= 0) begin
                    sp = cyc - last_inc;
                    if (sp < sp_min) sp_min = sp;
                    if (sp > sp_max) sp_max = sp;
                end
                last_inc = cyc;
                n_inc++;
            end
            prev_inc = m_fil_inc;
            if (m_pat_en) n_pe++;
            if (m_done && !done_seen) begin
                done_seen = 1'b1;
                check("scoreboard_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    check("fault_cnt", m_fc, e_mon.fc);
                    check("detect_cnt", m_dc, e_mon.dc);
                    check("pat_en_cycles", n_pe, e_mon.pat_en);
                    check("fil_inc_pulses", n_inc, e_mon.incs);
                    if (e_mon.spacing > 0) begin
                        check("fil_inc_spacing_min", sp_min, e_mon.spacing);
                        check("fil_inc_spacing_max", sp_max, e_mon.spacing);
                    end
                end
            end
        end
    end

    task automatic clean_reset();
        mon_clr = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic launch(input int s, input int f, input int md, input int t, input exp_t e);
        sel = s; nf[s] = f; mode[s] = md; tgt[s] = t;
        mask = '0;
        mask[$urandom_range(0, OB-1)] = 1'b1;
        clean_reset();
        exp_q.push_back(e);
        start_v[s] = 1'b1;
    endtask

    task automatic wait_done(input int s);
        int k = 0;
        while (!done_v[s] && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_within_budget", done_v[s], 1);
        if (!done_v[s] && exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1 start_v[s] = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; nf[i] = 1; mode[i] = 0; tgt[i] = 0;
        end
        sel = 0;
        mask = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_fil_inc", fil_inc_v[0], 0);
        check("rst_pat_rst", pat_rst_v[0], 0);
        check("rst_pat_en", pat_en_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_fault_cnt", fc_a, 0);
        check("rst_detect_cnt", dc_a, 0);

        // Three faults, always mismatching; start held high through DONE.
        launch(0, 3, 1, 0, '{fc: 3, dc: 3, pat_en: 12, incs: 3, spacing: 8});
        @(posedge clk); #1;
        check("inject_fil_inc", fil_inc_v[0], 1);
        check("inject_busy", busy_v[0], 1);
        @(posedge clk); #1;
        check("seed_pat_rst", pat_rst_v[0], 1);
        check("seed_fil_inc_low", fil_inc_v[0], 0);
        @(posedge clk); #1;
        check("apply_pat_en", pat_en_v[0], 1);
        k = 0;
        while (!done_v[0] && k < 2000) begin @(posedge clk); #1; k++; end
        repeat (20) @(posedge clk);
        #1;
        check("hold_done", done_v[0], 1);
        check("hold_busy", busy_v[0], 0);
        check("hold_fault_cnt", fc_a, 3);
        check("hold_no_restart", n_inc, 3);
        start_v[0] = 1'b0;

        // Clean responses: nothing detected, full windows.
        launch(0, 3, 0, 0, '{fc: 3, dc: 0, pat_en: 12, incs: 3, spacing: 8});
        wait_done(0);
        // Mismatch only on the last pattern, seen through the DRAIN compare.
        launch(0, 1, 2, 4, '{fc: 1, dc: 1, pat_en: 4, incs: 1, spacing: 0});
        wait_done(0);
        // Mismatch on a middle pattern of both faults.
        launch(0, 2, 2, 3, '{fc: 2, dc: 2, pat_en: 8, incs: 2, spacing: 8});
        wait_done(0);
        // Only the first of three faults mismatches: det must clear per fault.
        launch(0, 3, 3, 0, '{fc: 3, dc: 1, pat_en: 12, incs: 3, spacing: 8});
        wait_done(0);
        // FIL_END already high at start: one fault still evaluated.
        launch(0, 0, 1, 0, '{fc: 1, dc: 1, pat_en: 4, incs: 1, spacing: 0});
        wait_done(0);

        // Reset during APPLY of the second fault, then a clean restart.
        sel = 0; nf[0] = 3; mode[0] = 1;
        clean_reset();
        start_v[0] = 1'b1;
        k = 0;
        while (!(n_inc == 2 && pat_en_v[0]) && k < 200) begin @(posedge clk); #1; k++; end
        check("abort_reached_apply2", pat_en_v[0], 1);
        rst = 1'b0;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_fault_cnt", fc_a, 0);
        check("abort_detect_cnt", dc_a, 0);
        check("abort_fil_inc", fil_inc_v[0], 0);
        check("abort_pat_en", pat_en_v[0], 0);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_idle_no_inject", n_inc, 2);
        launch(0, 3, 1, 0, '{fc: 3, dc: 3, pat_en: 12, incs: 3, spacing: 8});
        wait_done(0);

        // Fault dropping: mismatch on the 2nd compared pattern -> 3 PAT_EN.
        launch(1, 2, 2, 2, '{fc: 2, dc: 2, pat_en: 6, incs: 2, spacing: 7});
        wait_done(1);
        // Dropping enabled but nothing detected: full 64-pattern window.
        launch(1, 1, 0, 0, '{fc: 1, dc: 0, pat_en: 64, incs: 1, spacing: 0});
        wait_done(1);

        // 2-bit counters saturate at 3 over five detected faults.
        launch(2, 5, 1, 0, '{fc: 3, dc: 3, pat_en: 20, incs: 5, spacing: 8});
        wait_done(2);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_campaign_ctrl.md
# fault_campaign_ctrl

Sequencer that drives the fault-injection side of the LBIST mid section: it pulses `FIL_INC` to inject each fault, runs a window of test patterns through the faulty and fault-free CUTs, and compares `CUT_OP` against `FF_OP`. It counts injected and detected faults until `FIL_END` reports the fault list is exhausted. It sits between the TPG (which it steps and reseeds) and `mid`, and reports fault coverage to the top level.

## Interface

**Parameters**
- `OUT_BITS`, 26: width of `CUT_OP` / `FF_OP`.
- `PAT_PER_FAULT`, 64: patterns applied per injected fault; must be ≥1.
- `CNT_W`, 16: width of the fault and detection counters.
- `DROP`, 1: when 1, the pattern window ends as soon as a fault is detected (fault dropping).

**Ports**
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-low reset.
- `start`, input, 1: level-sampled in IDLE; begins a campaign.
- `FIL_INC`, output, 1: one-cycle pulse that injects the next fault.
- `FIL_END`, input, 1: high when the FIL has no further faults.
- `PAT_RST`, output, 1: one-cycle TPG reseed.
- `PAT_EN`, output, 1: TPG advance enable; the TPG presents a new `TEST_IP` on the cycle after `PAT_EN` is high.
- `CUT_OP`, input, OUT_BITS: faulty-CUT response.
- `FF_OP`, input, OUT_BITS: fault-free response.
- `busy`, output, 1: high from leaving IDLE until entering DONE.
- `done`, output, 1: high in DONE.
- `fault_cnt`, output, CNT_W: number of faults evaluated.
- `detect_cnt`, output, CNT_W: number of faults with at least one mismatch.

## Operation

**States:** IDLE, INJECT, SEED, APPLY, DRAIN, EVAL, DONE.
- **IDLE:** if `start`=1, go to INJECT and clear both counters.
- **INJECT:** `FIL_INC`=1 for this cycle only; clear the sticky `det` flag; go to SEED.
- **SEED:** `PAT_RST`=1; load the pattern counter `pc` with 0; go to APPLY.
- **APPLY:** `PAT_EN`=1; `pc` increments.
  - Leave to DRAIN when `pc`=PAT_PER_FAULT-1.
  - Also leave to DRAIN when DROP=1 and `det` is set.
- **Compare enable** `cmp_v` is `PAT_EN` delayed by one register. When `cmp_v`=1 and `CUT_OP`≠`FF_OP`, `det` is set. The compare is a full-width XOR-reduce.
- **DRAIN:** one cycle so the last applied pattern is compared; go to EVAL.
- **EVAL:**
  - `fault_cnt` increments by 1; `detect_cnt` increments by `det`.
  - If `FIL_END`=1, go to DONE; otherwise go to INJECT.
- **DONE:** hold the counters; `done`=1. Return to IDLE only on reset. A new `start` is ignored.
- **Counter saturation:** both counters saturate at all-ones and never wrap.
- **Reset values:** every output is 0, the state is IDLE, `pc`=0, `det`=0.

## Timing

- `FIL_INC` → first `PAT_EN`: 2 cycles (INJECT, then SEED, then APPLY).
- Per-fault cost without a drop: PAT_PER_FAULT+4 cycles (INJECT, SEED, PAT_PER_FAULT × APPLY, DRAIN, EVAL).
- With DROP=1, a mismatch seen by the compare in cycle t causes APPLY to exit in cycle t+1. At most one extra pattern is applied after detection.
- `FIL_END` is sampled only in EVAL. Assertion at any other time has no effect until the next EVAL.
- `FIL_INC` is never high on two consecutive cycles. At least PAT_PER_FAULT+3 cycles separate pulses without a drop, and at least 5 cycles with one.
- Reset mid-campaign (`rst`=0 on any edge) aborts the sequence and returns to IDLE next cycle with all outputs 0. The FIL is reset separately by the top level.
- `start` held high through DONE does not restart the campaign.
- If `FIL_END` is already 1 at `start`, the controller still evaluates one fault, then goes to DONE with `fault_cnt`=1.

## Structure

- Shared package `lbist_pkg` holds:
  - the state enum `fcc_state_t`;
  - the localparam encodings;
  - the default `OUT_BITS`/`CNT_W`.
- Sub-module `resp_cmp`: registered comparator. Inputs are `cmp_v`, `CUT_OP`, `FF_OP` and the `det` clear. Output is the sticky `det`. This keeps the wide XOR-reduce and its pipeline register isolated.
- The FSM, pattern counter and result counters stay in `fault_campaign_ctrl`.

## Test plan

- **Three-fault stub** (`FIL_END` rises after the 3rd `FIL_INC`), PAT_PER_FAULT=4, DROP=0, CUT_OP always ≠ FF_OP: expect 3 `FIL_INC` pulses spaced 8 cycles apart, `fault_cnt`=3, `detect_cnt`=3, `done`=1.
- **Same stub, CUT_OP==FF_OP always:** expect `fault_cnt`=3, `detect_cnt`=0, and exactly 12 `PAT_EN` cycles in total.
- **DROP=1, PAT_PER_FAULT=64, mismatch only on the 2nd compared pattern:** expect 3 `PAT_EN` cycles for that fault, then DRAIN and EVAL, with `detect_cnt` incremented by 1.
- **Mismatch only on the last pattern of a 4-pattern window, DROP=0:** detected through the DRAIN compare; `detect_cnt`=1.
- **`rst` driven low during APPLY of the 2nd fault:** next cycle IDLE, counters 0, `busy`=0, no `FIL_INC`. A following `start` restarts from a clean state.
- **CNT_W=2 with 5 always-detected faults:** `fault_cnt` and `detect_cnt` saturate at 3.
